// File: rtl/store_checker.sv
// Purpose : compares a core's observed stores against a programmed table of expected (address, data) stores.
// Latency : verdict (PASS/FAIL) is registered one clock after the deciding store or the timeout cycle.
// Backpres: none; the checker observes every cycle and never stalls the core.
module store_checker #(
  parameter int                 WIDTH   = 32,
  parameter int                 DEPTH   = 4,
  parameter logic [WIDTH-1:0]   IGN_LO  = WIDTH'(96),
  parameter logic [WIDTH-1:0]   IGN_HI  = WIDTH'(96),
  parameter int                 TIMEOUT = 1000,
  localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             exp_we,
  input  logic [IW-1:0]    exp_idx,
  input  logic [WIDTH-1:0] exp_adr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [IW:0]      match_cnt,
  output logic [WIDTH-1:0] err_adr,
  output logic [WIDTH-1:0] err_data
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  localparam logic [IW:0] DEPTH_C   = (IW+1)'(DEPTH);
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_ADR  = 2'b01;
  localparam logic [1:0] FC_DATA = 2'b10;
  localparam logic [1:0] FC_TMO  = 2'b11;

  state_t            state;
  logic [31:0]       tmo_cnt;
  logic [WIDTH-1:0]  tab_adr  [DEPTH];
  logic [WIDTH-1:0]  tab_data [DEPTH];

  logic [IW-1:0]     cur_idx;
  logic [IW:0]       match_nxt;
  logic [31:0]       tmo_nxt;
  logic              tmo_hit;
  logic              ignored;
  logic              store_cmp;
  logic              adr_ok;
  logic              data_ok;

  // Compare-side decode: which entry is next, whether this store is in the ignored window, and timeout expiry.
  always_comb begin
    cur_idx   = match_cnt[IW-1:0];
    match_nxt = match_cnt + 1'b1;
    tmo_nxt   = tmo_cnt + 32'd1;
    tmo_hit   = (tmo_nxt >= TIMEOUT_C);
    ignored   = (DataAdr >= IGN_LO) && (DataAdr <= IGN_HI);
    store_cmp = MemWrite && !ignored;
    adr_ok    = (DataAdr == tab_adr[cur_idx]);
    data_ok   = (WriteData == tab_data[cur_idx]);
  end

  // Expected table: no reset so the programmed contents survive a checker reset; frozen while a run is active.
  always_ff @(posedge clk) begin
    if (exp_we && (state != RUN) && (32'(exp_idx) < 32'(DEPTH))) begin
      tab_adr[exp_idx]  <= exp_adr;
      tab_data[exp_idx] <= exp_data;
    end
  end

  // Run-control FSM with registered status outputs, match counter, timeout counter and error capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      match_cnt <= '0;
      err_adr   <= '0;
      err_data  <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            match_cnt <= '0;
            err_adr   <= '0;
            err_data  <= '0;
            tmo_cnt   <= '0;
          end
        end
        RUN: begin
          tmo_cnt <= tmo_nxt;
          // A real store compare outranks a timeout landing on the same cycle.
          if (store_cmp) begin
            if (!adr_ok || !data_ok) begin
              state     <= FAIL;
              busy      <= 1'b0;
              done      <= 1'b1;
              fail_code <= adr_ok ? FC_DATA : FC_ADR;
              err_adr   <= DataAdr;
              err_data  <= WriteData;
            end else if (match_cnt != DEPTH_C) begin
              match_cnt <= match_nxt;
              if (match_nxt == DEPTH_C) begin
                state <= PASS;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
              end
            end
          end else if (tmo_hit) begin
            state     <= FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= FC_TMO;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_checker.sv
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        we1 = 1'b0;
  logic        we4 = 1'b0;
  logic [0:0]  idx1 = '0;
  logic [1:0]  idx4 = '0;
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_data = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;

  logic        busy1, done1, pass1;
  logic [1:0]  fc1;
  logic [1:0]  mc1;
  logic [31:0] ea1, ed1;
  logic        busy4, done4, pass4;
  logic [1:0]  fc4;
  logic [2:0]  mc4;
  logic [31:0] ea4, ed4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_checker #(.WIDTH(32), .DEPTH(1), .IGN_LO(32'd96), .IGN_HI(32'd96), .TIMEOUT(20)) u1 (
    .clk(clk), .reset(reset), .start(start1), .exp_we(we1), .exp_idx(idx1),
    .exp_adr(exp_adr), .exp_data(exp_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy1), .done(done1), .pass(pass1), .fail_code(fc1),
    .match_cnt(mc1), .err_adr(ea1), .err_data(ed1)
  );

  store_checker #(.WIDTH(32), .DEPTH(4), .IGN_LO(32'd96), .IGN_HI(32'd96), .TIMEOUT(1000)) u4 (
    .clk(clk), .reset(reset), .start(start4), .exp_we(we4), .exp_idx(idx4),
    .exp_adr(exp_adr), .exp_data(exp_data), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy4), .done(done4), .pass(pass4), .fail_code(fc4),
    .match_cnt(mc4), .err_adr(ea4), .err_data(ed4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [0:0] i, input logic [31:0] a, input logic [31:0] d);
    we1 = 1'b1; idx1 = i; exp_adr = a; exp_data = d;
    tick();
    we1 = 1'b0;
  endtask

  task automatic wr4(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    we4 = 1'b1; idx4 = i; exp_adr = a; exp_data = d;
    tick();
    we4 = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic go1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic go4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_pass", 32'(pass1), 0);
    chk("rst_fc", 32'(fc1), 0);
    chk("rst_mc", 32'(mc1), 0);
    chk("rst_erradr", ea1, 0);
    chk("rst_errdata", ed1, 0);
    reset = 1'b0;
    tick();

    // DEPTH=1 pass with an ignored store first; index 1 is out of range and must not disturb entry 0
    wr1(1'b0, 32'd100, 32'd7);
    wr1(1'b1, 32'd200, 32'd9);
    go1();
    chk("run_busy", 32'(busy1), 1);
    store(32'd96, 32'd55);
    chk("ign_busy", 32'(busy1), 1);
    chk("ign_mc", 32'(mc1), 0);
    store(32'd100, 32'd7);
    chk("p_pass", 32'(pass1), 1);
    chk("p_done", 32'(done1), 1);
    chk("p_busy", 32'(busy1), 0);
    chk("p_mc", 32'(mc1), 1);
    chk("p_fc", 32'(fc1), 0);
    store(32'd104, 32'd7);
    chk("p_hold_pass", 32'(pass1), 1);
    chk("p_hold_fc", 32'(fc1), 0);

    // Address mismatch
    go1();
    chk("restart_mc", 32'(mc1), 0);
    chk("restart_done", 32'(done1), 0);
    store(32'd104, 32'd7);
    chk("am_done", 32'(done1), 1);
    chk("am_pass", 32'(pass1), 0);
    chk("am_fc", 32'(fc1), 1);
    chk("am_erradr", ea1, 104);
    chk("am_errdata", ed1, 7);

    // Data mismatch
    go1();
    chk("restart_fc", 32'(fc1), 0);
    chk("restart_erradr", ea1, 0);
    store(32'd100, 32'd8);
    chk("dm_fc", 32'(fc1), 2);
    chk("dm_erradr", ea1, 100);
    chk("dm_errdata", ed1, 8);

    // Timeout after exactly 20 RUN cycles; a start and a table write mid-run must both be ignored
    go1();
    for (int i = 1; i <= 19; i++) begin
      if (i == 5) start1 = 1'b1;
      if (i == 7) begin we1 = 1'b1; idx1 = 1'b0; exp_adr = 32'd300; exp_data = 32'd3; end
      tick();
      start1 = 1'b0;
      we1 = 1'b0;
      chk($sformatf("tmo_busy_%0d", i), 32'(busy1), 1);
    end
    tick();
    chk("tmo_done", 32'(done1), 1);
    chk("tmo_fc", 32'(fc1), 3);
    chk("tmo_pass", 32'(pass1), 0);

    // Matching store on the expiry cycle wins over the timeout; also proves entry 0 is still (100,7)
    go1();
    for (int i = 1; i <= 19; i++) tick();
    chk("edge_busy", 32'(busy1), 1);
    store(32'd100, 32'd7);
    chk("edge_pass", 32'(pass1), 1);
    chk("edge_fc", 32'(fc1), 0);
    chk("edge_mc", 32'(mc1), 1);

    // DEPTH=4: two matches, then an asynchronous reset between edges
    wr4(2'd0, 32'd200, 32'd1);
    wr4(2'd1, 32'd204, 32'd2);
    wr4(2'd2, 32'd208, 32'd3);
    wr4(2'd3, 32'd212, 32'd4);
    go4();
    store(32'd200, 32'd1);
    store(32'd204, 32'd2);
    chk("d4_mc2", 32'(mc4), 2);
    chk("d4_busy", 32'(busy4), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy4), 0);
    chk("ar_mc", 32'(mc4), 0);
    chk("ar_done", 32'(done4), 0);
    chk("ar_pass1", 32'(pass1), 0);
    chk("ar_done1", 32'(done1), 0);
    chk("ar_erradr", ea4, 0);
    #1;
    reset = 1'b0;
    tick();

    // Full DEPTH=4 run after reset, with an ignored store interleaved
    go4();
    store(32'd200, 32'd1);
    store(32'd204, 32'd2);
    store(32'd96, 32'd77);
    chk("d4_ign_mc", 32'(mc4), 2);
    store(32'd208, 32'd3);
    store(32'd212, 32'd4);
    chk("d4_pass", 32'(pass4), 1);
    chk("d4_mc4", 32'(mc4), 4);
    chk("d4_fc", 32'(fc4), 0);
    store(32'd200, 32'd1);
    chk("d4_sat_mc", 32'(mc4), 4);
    chk("d4_err_data", ed4, 0);

    // Table of the DEPTH=1 checker survived the reset
    go1();
    store(32'd100, 32'd7);
    chk("keep_pass", 32'(pass1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter WIDTH, 32, width of DataAdr, WriteData and expected-table entries.
REQ-002 Parameter DEPTH, 4, number of expected store entries (>=1); index width IW = max(1, clog2(DEPTH)).
REQ-003 Parameter IGN_LO, 96, lowest address of the ignored-store window.
REQ-004 Parameter IGN_HI, 96, highest address of the ignored-store window (IGN_HI >= IGN_LO).
REQ-005 Parameter TIMEOUT, 1000, maximum RUN cycles before a timeout fail; counter width 32.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 start  in  1  one-cycle pulse that begins a check run.
REQ-009 exp_we  in  1  expected-table write strobe.
REQ-010 exp_idx  in  IW  expected-table entry index.
REQ-011 exp_adr  in  WIDTH  expected store address.
REQ-012 exp_data  in  WIDTH  expected store data.
REQ-013 MemWrite  in  1  observed store strobe from the core.
REQ-014 DataAdr  in  WIDTH  observed store address.
REQ-015 WriteData  in  WIDTH  observed store data.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  high in PASS or FAIL.
REQ-018 pass  out  1  high only in PASS.
REQ-019 fail_code  out  2  00 none, 01 address mismatch, 10 data mismatch, 11 timeout.
REQ-020 match_cnt  out  IW+1  number of expected entries matched so far.
REQ-021 err_adr  out  WIDTH  DataAdr of the store that caused a mismatch fail.
REQ-022 err_data  out  WIDTH  WriteData of the store that caused a mismatch fail.

Function
REQ-023 The FSM SHALL have states IDLE, RUN, PASS, FAIL.
REQ-024 The expected table SHALL be written at exp_we in any state except RUN; exp_we in RUN is ignored; out-of-range exp_idx is ignored.
REQ-025 IDLE/PASS/FAIL + start SHALL enter RUN next cycle and clear match_cnt, fail_code, err_adr, err_data, and the timeout counter.
REQ-026 start during RUN SHALL be ignored.
REQ-027 In RUN, a store with IGN_LO <= DataAdr <= IGN_HI SHALL be ignored (no compare, no count).
REQ-028 In RUN, any other store SHALL be compared against entry match_cnt; address compared first, then data.
REQ-029 An address mismatch SHALL enter FAIL with fail_code 01; otherwise a data mismatch SHALL enter FAIL with fail_code 10; either case SHALL capture err_adr/err_data.
REQ-030 A full match SHALL increment match_cnt; if the new value equals DEPTH, enter PASS the next cycle.
REQ-031 The timeout counter SHALL increment every RUN cycle; on the cycle it reaches TIMEOUT without a store event, enter FAIL with fail_code 11.
REQ-032 A store compare in the same cycle as timeout expiry SHALL take priority over the timeout.
REQ-033 MemWrite in IDLE, PASS or FAIL SHALL have no effect; PASS and FAIL SHALL hold until start or reset.
REQ-034 Outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.
REQ-035 match_cnt SHALL saturate at DEPTH and never wrap.

Reset
REQ-036 reset SHALL force IDLE immediately, asynchronously, including mid-RUN.
REQ-037 On reset: busy=0, done=0, pass=0, fail_code=00, match_cnt=0, err_adr=0, err_data=0.
REQ-038 The expected table contents SHALL be preserved across reset.

Verification
REQ-039 DEPTH=1, table[0]=(100,7), start, stores (96,x),(100,7) -> pass=1, done=1, match_cnt=1, fail_code=00.
REQ-040 Table[0]=(100,7), start, store (104,7) -> FAIL, fail_code=01, err_adr=104, err_data=7.
REQ-041 Table[0]=(100,7), start, store (100,8) -> FAIL, fail_code=10, err_data=8.
REQ-042 TIMEOUT=20, start, no stores -> FAIL with fail_code=11 exactly 20 RUN cycles after entering RUN.
REQ-043 DEPTH=4, two matched stores, then reset asserted between clock edges -> outputs cleared immediately; a following start with four matching stores -> pass=1, match_cnt=4.
REQ-044 Store (100,7) arriving on the timeout-expiry cycle with DEPTH=1 -> PASS, not FAIL.
